// File: rtl/demux_dispatch.sv
// demux_dispatch: buffers one valid/ready word and issues it to a demux channel
// with a single-cycle strobe, using round-robin or addressed channel selection.
module demux_dispatch #(
  parameter int NUMOUT = 4,
  parameter int WIDTH  = 8,
  parameter int SBITS  = 2
) (
  input  logic              CK,
  input  logic              CLR,
  input  logic [WIDTH-1:0]  F,
  input  logic              FV,
  output logic              FR,
  input  logic [SBITS-1:0]  A,
  input  logic              MODE,
  input  logic [NUMOUT-1:0] RDY,
  output logic [WIDTH-1:0]  X,
  output logic [SBITS-1:0]  S,
  output logic              E,
  output logic [7:0]        CNT,
  output logic              ERR
);
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [SBITS-1:0] s_q, s_d, p_q, p_d, a_q, a_d, rr_t, tgt;
  logic [SBITS:0] idx;
  logic [7:0] cnt_q, cnt_d;
  logic e_q, e_d, err_q, err_d, mode_q, mode_d;
  logic found, go, take, drop;
  // Scan downward so the last hit is the first ready channel at or after P.
  always_comb begin
    found = 1'b0;
    rr_t = '0;
    idx = '0;
    for (int k = NUMOUT - 1; k >= 0; k--) begin
      idx = {1'b0, p_q} + (SBITS+1)'(k);
      idx = idx >= (SBITS+1)'(NUMOUT) ? idx - (SBITS+1)'(NUMOUT) : idx;
      if (|(RDY & (NUMOUT'(1) << idx))) begin
        found = 1'b1;
        rr_t = idx[SBITS-1:0];
      end
    end
  end
  assign go   = mode_q ? |(RDY & (NUMOUT'(1) << a_q)) : found;
  assign tgt  = mode_q ? a_q : rr_t;
  assign take = FV && state_q != WAIT;
  assign drop = MODE && ({1'b0, A} >= (SBITS+1)'(NUMOUT));
  assign FR   = state_q != WAIT;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    s_d = s_q;
    e_d = 1'b0;
    cnt_d = cnt_q;
    err_d = err_q;
    p_d = p_q;
    mode_d = mode_q;
    a_d = a_q;
    if (state_q == WAIT && go) begin
      state_d = ISSUE;
      s_d = tgt;
      e_d = 1'b1;
    end
    if (state_q == ISSUE) begin
      state_d = IDLE;
      cnt_d = cnt_q + 8'd1;
      p_d = mode_q ? p_q : (s_q == SBITS'(NUMOUT - 1) ? '0 : s_q + 1'b1);
    end
    // A rejected address leaves the previously issued word visible on X.
    if (take) begin
      state_d = drop ? IDLE : WAIT;
      err_d = err_q | drop;
      x_d = drop ? x_q : F;
      mode_d = drop ? mode_q : MODE;
      a_d = drop ? a_q : A;
    end
  end
  always_ff @(posedge CK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      x_q <= '0;
      s_q <= '0;
      e_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      p_q <= '0;
      mode_q <= 1'b0;
      a_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      s_q <= s_d;
      e_q <= e_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      p_q <= p_d;
      mode_q <= mode_d;
      a_q <= a_d;
    end
  end
  assign X = x_q;
  assign S = s_q;
  assign E = e_q;
  assign CNT = cnt_q;
  assign ERR = err_q;
endmodule

// File: tb/tb_demux_dispatch.sv
// tb_demux_dispatch: directed and randomized checks of a 4-channel and a 3-channel
// dispatcher sharing one producer stream, against a word-level reference model.
module tb_demux_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] f = '0;
  logic fv = 1'b0, mode = 1'b0;
  logic [1:0] a = '0;
  logic [3:0] rdy4 = '0;
  logic [2:0] rdy3 = '0;
  logic fr4, e4, err4, fr3, e3, err3;
  logic [7:0] x4, cnt4, x3, cnt3;
  logic [1:0] s4, s3;
  int vectors = 0, errors = 0;

  demux_dispatch #(.NUMOUT(4), .WIDTH(8), .SBITS(2)) dut4 (
    .CK(clk), .CLR(rst_n), .F(f), .FV(fv), .FR(fr4), .A(a), .MODE(mode), .RDY(rdy4),
    .X(x4), .S(s4), .E(e4), .CNT(cnt4), .ERR(err4));
  demux_dispatch #(.NUMOUT(3), .WIDTH(8), .SBITS(2)) dut3 (
    .CK(clk), .CLR(rst_n), .F(f), .FV(fv), .FR(fr3), .A(a), .MODE(mode), .RDY(rdy3),
    .X(x3), .S(s3), .E(e3), .CNT(cnt3), .ERR(err3));

  // Reference model: index 0 is the 4-channel instance, index 1 the 3-channel one.
  bit m_have[2];
  logic m_pm[2], m_e[2], m_err[2];
  logic [1:0] m_pa[2], m_s[2];
  logic [7:0] m_x[2], m_cnt[2];
  int m_ptr[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_have[i] = 0; m_pm[i] = 0; m_e[i] = 0; m_err[i] = 0;
      m_pa[i] = 0; m_s[i] = 0; m_x[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int n;
      int t;
      logic [3:0] r;
      bit ne;
      n = (i == 1) ? 3 : 4;
      r = (i == 1) ? {1'b0, rdy3} : rdy4;
      t = -1;
      ne = 0;
      if (m_e[i]) begin
        m_cnt[i] = m_cnt[i] + 8'd1;
        if (!m_pm[i]) m_ptr[i] = (int'(m_s[i]) + 1) % n;
      end
      if (m_have[i]) begin
        if (m_pm[i]) t = r[m_pa[i]] ? int'(m_pa[i]) : -1;
        else for (int k = 0; k < n; k++) if (t < 0 && r[(m_ptr[i] + k) % n]) t = (m_ptr[i] + k) % n;
        if (t >= 0) begin m_s[i] = 2'(t); ne = 1; m_have[i] = 0; end
      end else if (fv) begin
        if (mode && int'(a) >= n) m_err[i] = 1;
        else begin m_have[i] = 1; m_pm[i] = mode; m_pa[i] = a; m_x[i] = f; end
      end
      m_e[i] = ne;
    end
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fv = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input int inst, input logic [7:0] w, input logic md, input logic [1:0] ad);
    int n = 0;
    f = w; mode = md; a = ad; fv = 1'b1;
    while (((inst == 1) ? fr3 : fr4) !== 1'b1 && n < 50) begin tick(); n++; end
    vectors++;
    if (n >= 50) begin errors++; $display("FAIL send_timeout inst %0d: FR stayed %b, wanted 1", inst, (inst == 1) ? fr3 : fr4); end
    tick();
    fv = 1'b0;
  endtask

  task automatic wait_e(input int inst, input int max);
    int n = 0;
    do begin tick(); n++; end while (((inst == 1) ? e3 : e4) !== 1'b1 && n < max);
    vectors++;
    if (((inst == 1) ? e3 : e4) !== 1'b1) begin errors++; $display("FAIL e_timeout inst %0d: E=0 after %0d cycles, wanted 1", inst, n); end
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 6;
    if (fr4 !== 1'b1) begin errors++; $display("FAIL rst0_fr got %b want 1", fr4); end
    if (x4 !== 8'h00) begin errors++; $display("FAIL rst0_x got %h want 00", x4); end
    if (s4 !== 2'd0) begin errors++; $display("FAIL rst0_s got %0d want 0", s4); end
    if (e4 !== 1'b0) begin errors++; $display("FAIL rst0_e got %b want 0", e4); end
    if (cnt4 !== 8'd0) begin errors++; $display("FAIL rst0_cnt got %0d want 0", cnt4); end
    if (err4 !== 1'b0) begin errors++; $display("FAIL rst0_err got %b want 0", err4); end
    rdy4 = 4'b1111; rdy3 = 3'b111;
    send(0, 8'h11, 1'b0, 2'd0);
    tick(); tick();
    send(0, 8'h22, 1'b1, 2'd3);
    tick(); tick();
    vectors += 3;
    if (err3 !== 1'b1) begin errors++; $display("FAIL pre_err3 got %b want 1", err3); end
    if (cnt4 !== 8'd2) begin errors++; $display("FAIL pre_cnt4 got %0d want 2", cnt4); end
    if (s4 !== 2'd3) begin errors++; $display("FAIL pre_s4 got %0d want 3", s4); end
    rdy4 = '0; rdy3 = '0;
    send(0, 8'h5A, 1'b0, 2'd0);
    tick();
    vectors++;
    if (fr4 !== 1'b0) begin errors++; $display("FAIL wait_fr got %b want 0", fr4); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors += 2;
    if (fr4 !== 1'b1) begin errors++; $display("FAIL async_fr got %b want 1", fr4); end
    if (s4 !== 2'd0) begin errors++; $display("FAIL async_s got %0d want 0", s4); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    vectors += 7;
    if (fr4 !== 1'b1 || fr3 !== 1'b1) begin errors++; $display("FAIL rst1_fr got %b%b want 11", fr4, fr3); end
    if (x4 !== 8'h00) begin errors++; $display("FAIL rst1_x got %h want 00", x4); end
    if (s4 !== 2'd0) begin errors++; $display("FAIL rst1_s got %0d want 0", s4); end
    if (e4 !== 1'b0) begin errors++; $display("FAIL rst1_e got %b want 0", e4); end
    if (cnt4 !== 8'd0 || cnt3 !== 8'd0) begin errors++; $display("FAIL rst1_cnt got %0d/%0d want 0/0", cnt4, cnt3); end
    if (err3 !== 1'b0) begin errors++; $display("FAIL rst1_err got %b want 0", err3); end
    if (err4 !== 1'b0) begin errors++; $display("FAIL rst1_err4 got %b want 0", err4); end
    rdy4 = 4'b1111;
    send(0, 8'hC3, 1'b0, 2'd0);
    tick();
    vectors += 3;
    if (e4 !== 1'b1) begin errors++; $display("FAIL first_e got %b want 1", e4); end
    if (s4 !== 2'd0) begin errors++; $display("FAIL first_s got %0d want 0", s4); end
    if (x4 !== 8'hC3) begin errors++; $display("FAIL first_x got %h want c3", x4); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (e4 !== 1'b0) begin errors++; $display("FAIL async_e got %b want 0", e4); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] w[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int sent = 0, got = 0, last = -10;
    do_reset();
    rdy4 = 4'b1111; rdy3 = 3'b111; mode = 1'b0; a = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (fr4 && sent < 5) begin f = w[sent]; fv = 1'b1; sent++; end
      else fv = 1'b0;
      tick();
      if (e4 === 1'b1 && got < 5) begin
        vectors += 2;
        if (s4 !== 2'(got % 4)) begin errors++; $display("FAIL rr_s[%0d] got %0d want %0d", got, s4, got % 4); end
        if (x4 !== w[got]) begin errors++; $display("FAIL rr_x[%0d] got %h want %h", got, x4, w[got]); end
        if (got > 0) begin
          vectors++;
          if (cyc - last != 2) begin errors++; $display("FAIL rr_gap[%0d] got %0d want 2", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
    end
    fv = 1'b0;
    vectors += 2;
    if (got != 5) begin errors++; $display("FAIL rr_pulses got %0d want 5", got); end
    if (cnt4 !== 8'd5) begin errors++; $display("FAIL rr_cnt got %0d want 5", cnt4); end
  endtask

  task automatic test_skip();
    do_reset();
    rdy4 = 4'b1111; rdy3 = 3'b111; mode = 1'b0;
    send(0, 8'h01, 1'b0, 2'd0);
    wait_e(0, 4);
    tick();
    rdy4 = 4'b1001;
    send(0, 8'hA5, 1'b0, 2'd0);
    wait_e(0, 4);
    vectors += 2;
    if (s4 !== 2'd3) begin errors++; $display("FAIL skip_s got %0d want 3", s4); end
    if (x4 !== 8'hA5) begin errors++; $display("FAIL skip_x got %h want a5", x4); end
    tick();
    rdy4 = 4'b0000;
    send(0, 8'h3C, 1'b0, 2'd0);
    tick(); tick(); tick();
    vectors += 2;
    if (fr4 !== 1'b0) begin errors++; $display("FAIL stall_fr got %b want 0", fr4); end
    if (e4 !== 1'b0) begin errors++; $display("FAIL stall_e got %b want 0", e4); end
    rdy4 = 4'b0100;
    tick();
    vectors += 3;
    if (e4 !== 1'b1) begin errors++; $display("FAIL unstall_e got %b want 1", e4); end
    if (s4 !== 2'd2) begin errors++; $display("FAIL unstall_s got %0d want 2", s4); end
    if (x4 !== 8'h3C) begin errors++; $display("FAIL unstall_x got %h want 3c", x4); end
  endtask

  task automatic test_addressed();
    do_reset();
    rdy4 = 4'b1111; rdy3 = 3'b011;
    send(1, 8'h7E, 1'b1, 2'd2);
    tick(); tick();
    vectors += 2;
    if (e3 !== 1'b0) begin errors++; $display("FAIL addr_stall_e got %b want 0", e3); end
    if (fr3 !== 1'b0) begin errors++; $display("FAIL addr_stall_fr got %b want 0", fr3); end
    rdy3 = 3'b111;
    tick();
    vectors += 3;
    if (e3 !== 1'b1) begin errors++; $display("FAIL addr_e got %b want 1", e3); end
    if (s3 !== 2'd2) begin errors++; $display("FAIL addr_s got %0d want 2", s3); end
    if (x3 !== 8'h7E) begin errors++; $display("FAIL addr_x got %h want 7e", x3); end
    tick();
    send(1, 8'h99, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      vectors += 2;
      if (e3 !== 1'b0) begin errors++; $display("FAIL drop_e[%0d] got %b want 0", i, e3); end
      if (fr3 !== 1'b1) begin errors++; $display("FAIL drop_fr[%0d] got %b want 1", i, fr3); end
      tick();
    end
    vectors += 2;
    if (err3 !== 1'b1) begin errors++; $display("FAIL drop_err got %b want 1", err3); end
    if (cnt3 !== 8'd1) begin errors++; $display("FAIL drop_cnt got %0d want 1", cnt3); end
    send(1, 8'h42, 1'b0, 2'd0);
    wait_e(1, 4);
    vectors += 2;
    if (s3 !== 2'd0) begin errors++; $display("FAIL addr_p got %0d want 0", s3); end
    if (err3 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err3); end
  endtask

  task automatic test_wrap();
    int sent = 0, iss4 = 0, iss3 = 0;
    do_reset();
    rdy4 = 4'b1111; rdy3 = 3'b111; mode = 1'b0; a = '0;
    for (int cyc = 0; cyc < 600 && iss4 < 256; cyc++) begin
      fv = sent < 256;
      f = 8'($urandom);
      if (fr4 && fv) sent++;
      tick();
      if (e3 === 1'b1) begin
        vectors++;
        if (s3 !== 2'(iss3 % 3)) begin errors++; $display("FAIL wrap_s3[%0d] got %0d want %0d", iss3, s3, iss3 % 3); end
        iss3++;
      end
      if (e4 === 1'b1) iss4++;
    end
    fv = 1'b0;
    vectors += 2;
    if (iss4 != 256) begin errors++; $display("FAIL wrap_issued got %0d want 256", iss4); end
    if (cnt4 !== 8'd255) begin errors++; $display("FAIL wrap_cnt255 got %0d want 255", cnt4); end
    tick();
    vectors++;
    if (cnt4 !== 8'd0 || cnt3 !== 8'd0) begin errors++; $display("FAIL wrap_cnt0 got %0d/%0d want 0/0", cnt4, cnt3); end
  endtask

  task automatic test_mode_latch();
    do_reset();
    rdy4 = 4'b0000; rdy3 = 3'b111;
    send(0, 8'h99, 1'b1, 2'd1);
    mode = 1'b0; a = 2'd0;
    tick();
    rdy4 = 4'b0001;
    tick(); tick();
    vectors += 2;
    if (e4 !== 1'b0) begin errors++; $display("FAIL latch_e got %b want 0", e4); end
    if (fr4 !== 1'b0) begin errors++; $display("FAIL latch_fr got %b want 0", fr4); end
    rdy4 = 4'b0011;
    tick();
    vectors += 3;
    if (e4 !== 1'b1) begin errors++; $display("FAIL latch_issue_e got %b want 1", e4); end
    if (s4 !== 2'd1) begin errors++; $display("FAIL latch_s got %0d want 1", s4); end
    if (x4 !== 8'h99) begin errors++; $display("FAIL latch_x got %h want 99", x4); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      f = 8'($urandom);
      fv = 1'($urandom);
      mode = 1'($urandom);
      a = 2'($urandom);
      rdy4 = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      rdy3 = ($urandom_range(0, 3) == 0) ? 3'b0 : 3'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        logic [7:0] ox, oc;
        logic [1:0] os;
        logic oe, oerr, ofr;
        ox = i ? x3 : x4; oc = i ? cnt3 : cnt4; os = i ? s3 : s4;
        oe = i ? e3 : e4; oerr = i ? err3 : err4; ofr = i ? fr3 : fr4;
        vectors += 6;
        if (ox !== m_x[i]) begin errors++; $display("FAIL rand_x[%0d] cyc %0d got %h want %h", i, cyc, ox, m_x[i]); end
        if (os !== m_s[i]) begin errors++; $display("FAIL rand_s[%0d] cyc %0d got %0d want %0d", i, cyc, os, m_s[i]); end
        if (oe !== m_e[i]) begin errors++; $display("FAIL rand_e[%0d] cyc %0d got %b want %b", i, cyc, oe, m_e[i]); end
        if (oc !== m_cnt[i]) begin errors++; $display("FAIL rand_cnt[%0d] cyc %0d got %0d want %0d", i, cyc, oc, m_cnt[i]); end
        if (oerr !== m_err[i]) begin errors++; $display("FAIL rand_err[%0d] cyc %0d got %b want %b", i, cyc, oerr, m_err[i]); end
        if (ofr !== !m_have[i]) begin errors++; $display("FAIL rand_fr[%0d] cyc %0d got %b want %b", i, cyc, ofr, !m_have[i]); end
      end
    end
    fv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_skip();
    test_addressed();
    test_wrap();
    test_mode_latch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/demux_dispatch.md
Name: demux_dispatch

Overview:
- Sequencing controller for the demux primitive. Accepts a single valid/ready word stream and buffers one word.
- Selects a destination channel and drives the demux data, select and enable inputs for exactly one cycle per word.
- Supports round-robin distribution over ready consumers and addressed delivery. Sits between a producer and a demux whose NUMOUT outputs feed independent consumers.

Parameters:
- NUMOUT, 4, number of demux output channels (2..16, need not be a power of two)
- WIDTH, 8, data word width (matches the demux F/Z width)
- SBITS, 2, select width; must satisfy 2^SBITS >= NUMOUT

Ports:
- CK  input  1  clock; all state changes on rising edge
- CLR  input  1  reset, asynchronous, active-low
- F  input  WIDTH  producer data word
- FV  input  1  producer valid
- FR  output  1  ready to producer; a word transfers on a rising edge with FV=1 and FR=1
- A  input  SBITS  destination address, used only when MODE=1
- MODE  input  1  0 = round-robin, 1 = addressed; sampled with the word at transfer
- RDY  input  NUMOUT  per-channel consumer ready, bit i for demux output Zi
- X  output  WIDTH  buffered word, drives demux F
- S  output  SBITS  channel select, drives demux S
- E  output  1  issue strobe, drives demux E
- CNT  output  8  count of issued words, wraps 255 -> 0
- ERR  output  1  sticky flag: addressed word dropped

Behaviour:
- Reset (CLR=0, asynchronous, takes effect immediately):
  - state=IDLE; X=0, S=0, E=0, CNT=0, ERR=0; round-robin pointer P=0.
  - Any buffered word is discarded. E falls without waiting for CK.
  - FR=1 once CLR=1 (IDLE).
- Outputs X, S, E, CNT and ERR are registered. FR is decoded from state only; there is no combinational path from FV or RDY to FR.
- States IDLE, WAIT, ISSUE:
  - IDLE: FR=1, E=0. On transfer, latch F, MODE and A.
    - If MODE=1 and A>=NUMOUT: word dropped, ERR<=1, stay IDLE, CNT unchanged.
    - Otherwise -> WAIT.
  - WAIT: FR=0, E=0. Each cycle, compute target T.
    - MODE=1: T=A as latched.
    - MODE=0: T = first i with RDY[i]=1, scanning P, P+1, ... modulo NUMOUT.
    - If T exists and RDY[T]=1: S<=T, E<=1, -> ISSUE. Otherwise stay WAIT; S, E and P are unchanged.
  - ISSUE: E=1 for exactly this one cycle; X and S stable.
    - CNT<=CNT+1 (mod 256). If MODE=0, P<=(T+1) mod NUMOUT; P is unchanged in MODE=1.
    - FR=1. On transfer, latch the new word and evaluate it as in IDLE (dropped word -> IDLE with ERR set; else -> WAIT).
    - No transfer -> IDLE, E<=0.
- Timing:
  - Latency: transfer at edge t with target ready at edge t+1 -> E=1 during cycle t+1..t+2.
  - Peak throughput is one word per 2 cycles.
- Flow rules:
  - RDY is sampled only in WAIT. A RDY drop during ISSUE does not cancel the issue; consumers latch Zi while E=1.
  - Changes to MODE or A while in WAIT have no effect on the buffered word.
  - No channel ever ready: stall in WAIT indefinitely, FR=0.
- Wrap cases:
  - P wraps from NUMOUT-1 to 0. For non-power-of-2 NUMOUT (e.g. 3), select values >= NUMOUT are never driven.
  - CNT wraps silently.
- ERR is cleared only by CLR.

Test Plan:
- Reset: hold CLR=0 mid-WAIT with a word buffered, release -> E=0, S=0, X=0, CNT=0, ERR=0, FR=1. Next word goes to channel 0 under MODE=0 with RDY=4'b1111.
- Round-robin: RDY=4'b1111, MODE=0, send words 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back -> S sequence 0,1,2,3,0 with E pulses 2 cycles apart; X matches each word at its E pulse; CNT=5.
- Skip not-ready: P=1, RDY=4'b1001, MODE=0, send 0xA5 -> issued on S=3, P becomes 0. Next word with RDY=4'b0000 stalls in WAIT (FR=0). Raise RDY[2] -> issued on S=2 the following cycle.
- Addressed: NUMOUT=3, SBITS=2, MODE=1, send 0x7E with A=2 and RDY=3'b011 -> stalls; issues on S=2 when RDY[2] rises; P unchanged. Then send A=3 -> dropped, ERR=1, no E pulse, CNT unchanged, FR stays 1.
- Wrap: issue 256 words -> CNT returns to 0. With NUMOUT=3 in round-robin, S never equals 3 across 10 words (sequence 0,1,2,0,...).
- Mode latch: accept a word with MODE=1, A=1, RDY=0; toggle MODE=0 and A=0 while in WAIT; raise RDY=4'b0001, then RDY[1] -> word waits and issues only on S=1.
